// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_pkg
// Brief   : Shared types and defaults for the dual-lane MEM/WB stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_wb_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int REGADDR_W     = 5;
    localparam int MISS_LAT_DEF  = 4;
    localparam int DIRTY_LAT_DEF = 4;
    localparam int CNT_W_DEF     = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EVICT_A  = 3'd1,
        ST_REFILL_A = 3'd2,
        ST_EVICT_B  = 3'd3,
        ST_REFILL_B = 3'd4,
        ST_RELEASE  = 3'd5
    } state_e;

    // A miss only matters when the lane actually touches memory.
    function automatic logic qualify_miss(input logic miss, input logic memtoreg,
                                          input logic memwrite);
        return miss & (memtoreg | memwrite);
    endfunction

endpackage : mem_wb_pkg
`default_nettype wire

// File: rtl/mem_wb_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_if
// Brief   : MEM-side inputs and WB-side outputs of the dual-lane MEM/WB stage.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_wb_if
    import mem_wb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic                 regwritem,  regwritem2;
    logic                 memtoregm,  memtoregm2;
    logic                 memwritem,  memwritem2;
    logic [WIDTH-1:0]     aluoutm,    aluoutm2;
    logic [WIDTH-1:0]     readdatam,  readdatam2;
    logic [REGADDR_W-1:0] writeregm,  writeregm2;
    logic                 miss, miss2, dirty;

    logic                 regwritew,  regwritew2;
    logic [REGADDR_W-1:0] writeregw,  writeregw2;
    logic [WIDTH-1:0]     resultw,    resultw2;
    logic                 stallm;
    logic                 missbusy;

    modport master (
        output regwritem, regwritem2, memtoregm, memtoregm2,
               memwritem, memwritem2, aluoutm, aluoutm2,
               readdatam, readdatam2, writeregm, writeregm2,
               miss, miss2, dirty,
        input  regwritew, regwritew2, writeregw, writeregw2,
               resultw, resultw2, stallm, missbusy
    );

    modport slave (
        input  regwritem, regwritem2, memtoregm, memtoregm2,
               memwritem, memwritem2, aluoutm, aluoutm2,
               readdatam, readdatam2, writeregm, writeregm2,
               miss, miss2, dirty,
        output regwritew, regwritew2, writeregw, writeregw2,
               resultw, resultw2, stallm, missbusy
    );

endinterface : mem_wb_if
`default_nettype wire

// File: rtl/mem_wb_lane.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_lane
// Brief   : One lane's W register: captures the bundle or writes a bubble.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb_lane
    import mem_wb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_capture,
    input  wire logic                 i_regwrite,
    input  wire logic                 i_memtoreg,
    input  wire logic [WIDTH-1:0]     i_aluout,
    input  wire logic [WIDTH-1:0]     i_readdata,
    input  wire logic [REGADDR_W-1:0] i_writereg,
    output logic                      o_regwrite,
    output logic [REGADDR_W-1:0]      o_writereg,
    output logic [WIDTH-1:0]          o_result
);

    logic                 regwrite_q, regwrite_d;
    logic [REGADDR_W-1:0] writereg_q, writereg_d;
    logic [WIDTH-1:0]     result_q,   result_d;
    logic [WIDTH-1:0]     w_result;

    assign w_result = i_memtoreg ? i_readdata : i_aluout;

    // Outside a capture cycle only the write enable drops; the rest holds.
    always_comb begin
        regwrite_d = 1'b0;
        writereg_d = writereg_q;
        result_d   = result_q;
        if (i_capture) begin
            regwrite_d = i_regwrite;
            writereg_d = i_writereg;
            result_d   = w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            writereg_q <= '0;
            result_q   <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            writereg_q <= writereg_d;
            result_q   <= result_d;
        end
    end

    assign o_regwrite = regwrite_q;
    assign o_writereg = writereg_q;
    assign o_result   = result_q;

endmodule : mem_wb_lane
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage
// Brief   : Dual-lane MEM/WB register with cache-miss stall FSM.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MISS_LAT  = MISS_LAT_DEF,
    parameter int DIRTY_LAT = DIRTY_LAT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mem_wb_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_miss_load  = CNT_W'(MISS_LAT - 1);
    localparam logic [CNT_W-1:0] c_dirty_load = CNT_W'(DIRTY_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pendb_q, pendb_d;

    logic w_qa, w_qb;
    logic w_stall;
    logic w_capture;
    logic w_cnt_zero;

    assign w_qa       = qualify_miss(bus.miss,  bus.memtoregm,  bus.memwritem);
    assign w_qb       = qualify_miss(bus.miss2, bus.memtoregm2, bus.memwritem2);
    assign w_cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pendb_d   = pendb_q;
        w_stall   = 1'b0;
        w_capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_qa || w_qb) begin
                    w_stall = 1'b1;
                    pendb_d = w_qa & w_qb;
                    cnt_d   = bus.dirty ? c_dirty_load : c_miss_load;
                    if (w_qa) begin
                        state_d = bus.dirty ? ST_EVICT_A : ST_REFILL_A;
                    end else begin
                        state_d = bus.dirty ? ST_EVICT_B : ST_REFILL_B;
                    end
                end else begin
                    w_capture = 1'b1;
                end
            end

            ST_EVICT_A, ST_EVICT_B: begin
                w_stall = 1'b1;
                if (w_cnt_zero) begin
                    state_d = (state_q == ST_EVICT_A) ? ST_REFILL_A : ST_REFILL_B;
                    cnt_d   = c_miss_load;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end

            ST_REFILL_A: begin
                w_stall = 1'b1;
                if (!w_cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pendb_q) begin
                    // Lane B's dirty status is only valid once lane A has refilled.
                    state_d = bus.dirty ? ST_EVICT_B : ST_REFILL_B;
                    cnt_d   = bus.dirty ? c_dirty_load : c_miss_load;
                    pendb_d = 1'b0;
                end else begin
                    state_d = ST_RELEASE;
                end
            end

            ST_REFILL_B: begin
                w_stall = 1'b1;
                if (w_cnt_zero) begin
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end

            ST_RELEASE: begin
                w_capture = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pendb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pendb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pendb_q <= pendb_d;
        end
    end

    assign bus.stallm   = rst_n & w_stall;
    assign bus.missbusy = rst_n & (state_q != ST_IDLE);

    mem_wb_lane #(
        .WIDTH (WIDTH)
    ) u_lane_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_capture  (w_capture),
        .i_regwrite (bus.regwritem),
        .i_memtoreg (bus.memtoregm),
        .i_aluout   (bus.aluoutm),
        .i_readdata (bus.readdatam),
        .i_writereg (bus.writeregm),
        .o_regwrite (bus.regwritew),
        .o_writereg (bus.writeregw),
        .o_result   (bus.resultw)
    );

    mem_wb_lane #(
        .WIDTH (WIDTH)
    ) u_lane_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_capture  (w_capture),
        .i_regwrite (bus.regwritem2),
        .i_memtoreg (bus.memtoregm2),
        .i_aluout   (bus.aluoutm2),
        .i_readdata (bus.readdatam2),
        .i_writereg (bus.writeregm2),
        .o_regwrite (bus.regwritew2),
        .o_writereg (bus.writeregw2),
        .o_result   (bus.resultw2)
    );

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_wb_stage
// Brief   : Randomized scoreboard bench for the dual-lane MEM/WB stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int MISS  = 4;
    localparam int DIRTY = 4;

    typedef struct packed {
        logic        rw, mtr, mw, ms;
        logic [31:0] alu, rd;
        logic [4:0]  wr;
    } lane_t;

    typedef struct packed {
        logic        rw_a, rw_b;
        logic [4:0]  wr_a, wr_b;
        logic [31:0] res_a, res_b;
        int          stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_wb_if #(.WIDTH(32)) bus ();

    mem_wb_stage #(
        .WIDTH     (32),
        .MISS_LAT  (MISS),
        .DIRTY_LAT (DIRTY),
        .CNT_W     (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    bit   mon_en   = 1'b0;
    bit   drv_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input lane_t a, input lane_t b);
        bus.regwritem  = a.rw;  bus.regwritem2 = b.rw;
        bus.memtoregm  = a.mtr; bus.memtoregm2 = b.mtr;
        bus.memwritem  = a.mw;  bus.memwritem2 = b.mw;
        bus.aluoutm    = a.alu; bus.aluoutm2   = b.alu;
        bus.readdatam  = a.rd;  bus.readdatam2 = b.rd;
        bus.writeregm  = a.wr;  bus.writeregm2 = b.wr;
        bus.miss       = a.ms;  bus.miss2      = b.ms;
    endtask

    function automatic lane_t rand_lane();
        lane_t l;
        l.rw  = 1'($urandom_range(0, 1));
        l.mtr = ($urandom_range(0, 2) == 0);
        l.mw  = !l.mtr && ($urandom_range(0, 3) == 0);
        l.ms  = ($urandom_range(0, 3) == 0);
        l.alu = $urandom;
        l.rd  = $urandom;
        l.wr  = 5'($urandom_range(0, 31));
        return l;
    endfunction

    // Reference: a qualified miss costs MISS (+DIRTY if dirty) per lane plus one
    // detection cycle; the W register then shows the muxed bundle.
    task automatic run_txn(input lane_t a, input lane_t b, input bit da, input bit db);
        exp_t e;
        bit   qa, qb;
        int   len_a, len_b, l_tot;
        qa    = a.ms && (a.mtr || a.mw);
        qb    = b.ms && (b.mtr || b.mw);
        len_a = qa ? MISS + (da ? DIRTY : 0) : 0;
        len_b = qb ? MISS + (db ? DIRTY : 0) : 0;
        l_tot = (qa || qb) ? 1 + len_a + len_b : 0;
        e.rw_a  = a.rw;  e.rw_b  = b.rw;
        e.wr_a  = a.wr;  e.wr_b  = b.wr;
        e.res_a = a.mtr ? a.rd : a.alu;
        e.res_b = b.mtr ? b.rd : b.alu;
        e.stall = l_tot;
        exp_q.push_back(e);
        drive(a, b);
        for (int k = 0; k < l_tot; k++) begin
            bus.dirty = (qa && k < len_a) ? da : db;
            @(posedge clk); #1;
        end
        if (l_tot > 0) begin
            // The cache hits in the release cycle; miss lines are don't-care.
            bus.miss  = 1'($urandom_range(0, 1));
            bus.miss2 = 1'($urandom_range(0, 1));
        end
        bus.dirty = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    // Monitor / scoreboard
    exp_t held = '0;
    exp_t pend = '0;
    bit   pending    = 1'b0;
    bit   prev_stall = 1'b0;
    int   cur_stall  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pending) begin
                check("regwritew",  {31'd0, bus.regwritew},  {31'd0, pend.rw_a});
                check("regwritew2", {31'd0, bus.regwritew2}, {31'd0, pend.rw_b});
                check("writeregw",  {27'd0, bus.writeregw},  {27'd0, pend.wr_a});
                check("writeregw2", {27'd0, bus.writeregw2}, {27'd0, pend.wr_b});
                check("resultw",    bus.resultw,  pend.res_a);
                check("resultw2",   bus.resultw2, pend.res_b);
                held    = pend;
                pending = 1'b0;
            end else if (prev_stall) begin
                check("bubble_rw",   {31'd0, bus.regwritew},  32'd0);
                check("bubble_rw2",  {31'd0, bus.regwritew2}, 32'd0);
                check("hold_wr",     {27'd0, bus.writeregw},  {27'd0, held.wr_a});
                check("hold_wr2",    {27'd0, bus.writeregw2}, {27'd0, held.wr_b});
                check("hold_res",    bus.resultw,  held.res_a);
                check("hold_res2",   bus.resultw2, held.res_b);
            end
            check("missbusy", {31'd0, bus.missbusy}, {31'd0, prev_stall});
            if (bus.stallm) begin
                cur_stall++;
                prev_stall = 1'b1;
            end else begin
                if (exp_q.size() > 0) begin
                    pend = exp_q.pop_front();
                    check("stall_len", cur_stall, pend.stall);
                    pending = 1'b1;
                end else if (!drv_done) begin
                    check("unexpected_capture", 32'd1, 32'd0);
                end
                cur_stall  = 0;
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        lane_t a, b, z;
        z = '0;
        drive(z, z);
        bus.dirty     = 1'b0;
        // Misses under reset must not raise stallm.
        bus.miss      = 1'b1;
        bus.memtoregm = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stallm",   {31'd0, bus.stallm},    32'd0);
        check("rst_missbusy", {31'd0, bus.missbusy},  32'd0);
        check("rst_rw",       {31'd0, bus.regwritew}, 32'd0);
        check("rst_rw2",      {31'd0, bus.regwritew2}, 32'd0);
        check("rst_res",      bus.resultw,  32'd0);
        check("rst_res2",     bus.resultw2, 32'd0);
        drive(z, z);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // No miss: lane A load, lane B ALU
        a = z; a.rw = 1; a.mtr = 1; a.rd = 32'hDEADBEEF; a.alu = 32'h1234; a.wr = 5'd3;
        b = z; b.rw = 1; b.alu = 32'h10; b.rd = 32'h5555; b.wr = 5'd4;
        run_txn(a, b, 1'b0, 1'b0);
        // Lane A clean load miss, lane B hit
        a.ms = 1; a.rd = 32'hCAFEF00D;
        b.alu = 32'h20;
        run_txn(a, b, 1'b0, 1'b0);
        // Lane A dirty store miss
        a = z; a.rw = 0; a.mw = 1; a.ms = 1; a.alu = 32'h100; a.wr = 5'd7;
        run_txn(a, b, 1'b1, 1'b0);
        // Both lanes clean miss
        a = z; a.rw = 1; a.mtr = 1; a.ms = 1; a.rd = 32'hA5A5A5A5; a.wr = 5'd9;
        b = z; b.rw = 1; b.mtr = 1; b.ms = 1; b.rd = 32'h5A5A5A5A; b.wr = 5'd10;
        run_txn(a, b, 1'b0, 1'b0);
        // Both lanes, both dirty; then B-only dirty
        run_txn(a, b, 1'b1, 1'b1);
        a.ms = 0;
        run_txn(a, b, 1'b0, 1'b1);
        // Miss on a non-memory lane is ignored
        a = z; a.rw = 1; a.ms = 1; a.alu = 32'h77; a.wr = 5'd11;
        b = z; b.rw = 1; b.ms = 1; b.alu = 32'h88; b.wr = 5'd12;
        run_txn(a, b, 1'b1, 1'b1);

        for (int i = 0; i < 150; i++) begin
            a = rand_lane();
            b = rand_lane();
            run_txn(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drv_done = 1'b1;
        @(negedge clk); #1;
        mon_en = 1'b0;
        check("queue_drained", exp_q.size(), 32'd0);

        // Reset while REFILL_A is at count 2
        @(posedge clk); #1;
        a = z; a.rw = 1; a.mtr = 1; a.ms = 1; a.rd = 32'h13579BDF; a.wr = 5'd21;
        b = z; b.rw = 1; b.alu = 32'h2468; b.wr = 5'd22;
        drive(a, b);
        bus.dirty = 1'b0;
        @(negedge clk);
        check("mid_stall", {31'd0, bus.stallm}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_stallm",   {31'd0, bus.stallm},   32'd0);
        check("mid_rst_missbusy", {31'd0, bus.missbusy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.miss = 1'b0;
        @(negedge clk);
        check("post_rst_missbusy", {31'd0, bus.missbusy},  32'd0);
        check("post_rst_stallm",   {31'd0, bus.stallm},    32'd0);
        check("post_rst_rw",       {31'd0, bus.regwritew},  32'd0);
        check("post_rst_rw2",      {31'd0, bus.regwritew2}, 32'd0);
        check("post_rst_wr",       {27'd0, bus.writeregw},  32'd0);
        check("post_rst_wr2",      {27'd0, bus.writeregw2}, 32'd0);
        check("post_rst_res",      bus.resultw,  32'd0);
        check("post_rst_res2",     bus.resultw2, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("resume_res", bus.resultw, 32'h13579BDF);
        check("resume_rw",  {31'd0, bus.regwritew}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Dual-lane MEM/WB pipeline stage. Sits directly downstream of the memory stage and consumes its per-lane load data plus the cache hit/miss/dirty status.
- Registers both lanes' writeback bundles and selects the writeback result (ALU result or load data).
- Owns the miss-stall FSM: freezes the upstream pipeline on a cache miss, counts refill/eviction latency and injects WB bubbles.
- Both lanes always retire together, in order.

Parameters:
- WIDTH, 32, datapath width of ALU result and load data.
- MISS_LAT, 4, refill cycles per missing access; must be >=1.
- DIRTY_LAT, 4, extra eviction cycles when dirty is sampled high; must be >=1.
- CNT_W, 4, latency counter width; must satisfy 2^CNT_W > max(MISS_LAT, DIRTY_LAT).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- regwritem, regwritem2  in  1  lane A/B writes a register
- memtoregm, memtoregm2  in  1  lane A/B is a load
- memwritem, memwritem2  in  1  lane A/B is a store
- aluoutm, aluoutm2  in  WIDTH  lane A/B ALU result / address
- readdatam, readdatam2  in  WIDTH  lane A/B load data from the memory stage
- writeregm, writeregm2  in  5  lane A/B destination register
- miss, miss2, dirty  in  1  cache status from the memory stage; dirty applies to the access being served
- regwritew, regwritew2  out  1  lane A/B WB write enable
- writeregw, writeregw2  out  5  lane A/B WB destination
- resultw, resultw2  out  WIDTH  lane A/B WB value
- stallm  out  1  freeze IF..MEM registers this cycle
- missbusy  out  1  FSM is not in IDLE (performance counter hook)

Behaviour:
- Reset (rst_n low at a rising edge): state to IDLE; counter to 0; all W outputs to 0. While rst_n is low, stallm=0 and missbusy=0 combinationally. Reset mid-refill abandons the refill with no WB write.
- Qualified miss: qa = miss & (memtoregm|memwritem); qb = miss2 & (memtoregm2|memwritem2).
- States: IDLE, EVICT_A, REFILL_A, EVICT_B, REFILL_B, RELEASE.
- IDLE, no qa/qb:
  - stallm=0.
  - Next edge captures both lanes: resultw = memtoregm ? readdatam : aluoutm. Same rule for lane B.
- IDLE, qa or qb:
  - stallm=1 combinationally in the same cycle.
  - Next edge writes a bubble: regwritew, regwritew2 = 0; other W fields hold.
  - Latch pendb = qa & qb.
  - Serve lane A first if qa, else lane B.
  - Go to EVICT_x if dirty, else REFILL_x.
  - Load counter with the matching latency minus 1.
- EVICT_x: stallm=1. Counter decrements; at 0, go to REFILL_x with counter = MISS_LAT-1.
- REFILL_A at counter 0:
  - If pendb: go to EVICT_B if dirty is sampled now, else REFILL_B, with the matching load; clear pendb.
  - Otherwise go to RELEASE.
- REFILL_B at counter 0: go to RELEASE.
- All non-IDLE, non-RELEASE states: stallm=1 and a bubble is written each cycle.
- RELEASE:
  - stallm=0.
  - Capture both lanes unconditionally; miss/miss2 are ignored because the cache now hits.
  - Next state IDLE.
- Stall length: 1 + sum over served lanes of (MISS_LAT + DIRTY_LAT if dirty) cycles; RELEASE follows.
- A miss on a lane with neither memtoreg nor memwrite set is ignored.
- A hitting lane paired with a missing lane is held and retires in the same RELEASE cycle.
- missbusy = (state != IDLE).

Decomposition:
- Package mem_wb_pkg: state enum (3-bit encoding), WIDTH default, REGADDR_W=5, latency defaults.
- Sub-module mem_wb_lane, instantiated twice: one lane's W register with bubble/capture control and the result mux.
- The FSM and counter live in the top module.

Test Plan:
- No misses, lane A load (readdatam=0xDEADBEEF), lane B ALU (aluoutm2=0x10) -> next cycle resultw=0xDEADBEEF, resultw2=0x10, both regwritew=1, stallm never high.
- Lane A clean load miss, MISS_LAT=4 -> stallm high 5 cycles, 5 bubbles, RELEASE captures readdatam, lane B retires the same cycle.
- Lane A dirty store miss, DIRTY_LAT=4, MISS_LAT=4 -> stallm high 9 cycles, path IDLE->EVICT_A->REFILL_A->RELEASE.
- Both lanes clean miss -> stallm high 1+4+4=9 cycles, REFILL_A then REFILL_B, single RELEASE.
- miss=1 with memtoregm=memwritem=0 -> no stall, normal capture.
- rst_n low during REFILL_A count 2 -> next cycle state IDLE, all W outputs 0, stallm 0, no WB write.
